// File: rtl/onehot_decoder_pkg.sv
// rtl/onehot_decoder_pkg.sv - shared constants and types for the one-hot decoder
//
// Purpose : default widths, occupancy state type and beat counter width.
// Ports   : none (package).
// Optional: ONEHOT_DECODER_COUNT_EN uses CNT_W for the beat_cnt port.

package onehot_decoder_pkg;

   localparam int IDX_W_DEF = 3;
   localparam int OUT_W_DEF = 8;
   localparam int CNT_W     = 16;

   // Number of beats currently held (output register plus skid entry).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/onehot_decoder_dec.sv
// rtl/onehot_decoder_dec.sv - combinational index to one-hot conversion with range flag
//
// Purpose : onehot_out[i] = (idx_in == i); in_range_out = (idx_in < OUT_W).
//           An out-of-range index yields an all-zero vector.
// Ports   : idx_in       - encoded index
//           onehot_out   - decoded one-hot vector
//           in_range_out - index addresses a real output bit

module onehot_dec #(
   parameter int IDX_W = 3,
   parameter int OUT_W = 8
) (
   input  logic [IDX_W-1:0] idx_in,
   output logic [OUT_W-1:0] onehot_out,
   output logic             in_range_out
);

   always_comb begin
      onehot_out = '0;
      for (int i = 0; i < OUT_W; i++) begin
         onehot_out[i] = (32'(idx_in) == 32'(i));
      end
   end

   assign in_range_out = (32'(idx_in) < 32'(OUT_W));

endmodule

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - registered index-to-one-hot decoder with 2-entry skid buffer
//
// Purpose : decodes encoded_in into a one-hot data_out behind a valid/ready
//           handshake on both sides. Out-of-range indices are consumed,
//           dropped and flagged with a one-cycle err_out pulse.
// Ports   : clk, rst_n (synchronous, active-low)
//           encoded_in, valid_in, ready_out  - upstream handshake
//           data_out, valid_out, ready_in    - downstream handshake
//           err_out                          - out-of-range beat consumed
//           beat_cnt (ONEHOT_DECODER_COUNT_EN only) - output transfers since reset
// Optional: macro ONEHOT_DECODER_COUNT_EN adds the beat_cnt port and counter.

module onehot_decoder
   import onehot_decoder_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] encoded_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [OUT_W-1:0] data_out,
   output logic             valid_out,
   input  logic             ready_in,
   output logic             err_out
`ifdef ONEHOT_DECODER_COUNT_EN
   ,
   output logic [CNT_W-1:0] beat_cnt
`endif
);

   // With a full index space every index is legal and err_out never fires.
   localparam bit ERR_POSSIBLE = (OUT_W < (1 << IDX_W));

   occ_e             state_q, state_d;
   logic [IDX_W-1:0] skid_q, skid_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             err_q, err_d;

   logic [IDX_W-1:0] dec_idx;
   logic [OUT_W-1:0] dec_onehot;
   logic             dec_in_range;
   logic             take;
   logic             take_ok;
   logic             xfer;

   // The skid entry only competes for the decoder in TWO, where no input is
   // accepted, so a single decoder serves both load paths. Only in-range
   // indices ever reach the skid register.
   assign dec_idx = (state_q == TWO) ? skid_q : encoded_in;

   onehot_dec #(
      .IDX_W (IDX_W),
      .OUT_W (OUT_W)
   ) u_dec (
      .idx_in       (dec_idx),
      .onehot_out   (dec_onehot),
      .in_range_out (dec_in_range)
   );

   assign ready_out = rst_n && (state_q != TWO);
   assign valid_out = (state_q != EMPTY);
   assign data_out  = data_q;
   assign err_out   = err_q;

   assign take    = valid_in && ready_out;
   assign take_ok = take && dec_in_range;
   assign xfer    = valid_out && ready_in;

   always_comb begin
      state_d = state_q;
      skid_d  = skid_q;
      data_d  = data_q;
      err_d   = ERR_POSSIBLE ? (take && !dec_in_range) : 1'b0;
      case (state_q)
         EMPTY: begin
            if (take_ok) begin
               state_d = ONE;
               data_d  = dec_onehot;
            end
         end
         ONE: begin
            if (take_ok && xfer) begin
               data_d = dec_onehot;
            end else if (take_ok) begin
               state_d = TWO;
               skid_d  = encoded_in;
            end else if (xfer) begin
               state_d = EMPTY;
               data_d  = '0;
            end
         end
         TWO: begin
            if (xfer) begin
               state_d = ONE;
               data_d  = dec_onehot;
            end
         end
         default: begin
            state_d = EMPTY;
            data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         skid_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         skid_q  <= skid_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

`ifdef ONEHOT_DECODER_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Wraps naturally at 2**CNT_W.
   always_comb begin
      cnt_d = cnt_q;
      if (xfer) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign beat_cnt = cnt_q;
`endif

endmodule

// File: doc/onehot_decoder.md
Name: onehot_decoder

Overview:
- Registered index-to-one-hot decoder: the receiving end of the team's 8-to-3 priority encoder.
- Takes an encoded index plus valid, and produces the matching one-hot vector (data_out[i]=1 for index i).
- Valid/ready handshake on both sides, with a 2-entry skid buffer, so it can sit between the encoder and a stalling consumer (grant/select logic).
- Out-of-range indices are dropped and flagged.

Parameters:
- IDX_W, 3, width of encoded_in.
- OUT_W, 8, width of one-hot data_out; must satisfy 1 <= OUT_W <= 2**IDX_W. Indices >= OUT_W are out of range.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- encoded_in  input  IDX_W  index to decode
- valid_in  input  1  encoded_in is valid
- ready_out  output  1  block can accept a beat this cycle
- data_out  output  OUT_W  one-hot decoded vector
- valid_out  output  1  data_out is valid
- ready_in  input  1  downstream accepts data_out this cycle
- err_out  output  1  one-cycle pulse: an out-of-range index was consumed

Behaviour:
- Reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on a rising clk edge.
  - While rst_n=0 at an edge: data_out=0, valid_out=0, err_out=0, occupancy=EMPTY.
  - ready_out=0 while rst_n=0 (combinational on rst_n); ready_out=1 on the first cycle after release.
- Reset mid-operation discards all buffered beats with no err pulse; downstream sees valid_out drop at the next edge.
- Input accept: valid_in && ready_out at an edge.
- Output transfer: valid_out && ready_in at an edge.
- Occupancy FSM, counting beats held, with states EMPTY, ONE, TWO:
  - EMPTY: accept -> ONE. No accept -> EMPTY.
  - ONE: accept and transfer -> ONE (pass-through). Accept only -> TWO. Transfer only -> EMPTY. Neither -> ONE.
  - TWO: ready_out=0. Transfer -> ONE (the skid entry moves to the output register). Otherwise -> TWO.
- ready_out = (state != TWO), registered. It is not combinationally dependent on ready_in.
- Latency: a beat accepted at edge N is presented with valid_out=1 from edge N+1 when the output register is free.
- Full-throughput rule: ready_in held 1 gives one beat per cycle.
- Stall rule: while valid_out && !ready_in, data_out is held stable.
- Ordering: strict FIFO order; no beat is lost or duplicated.
- Decode: data_out = 1 << encoded_in. Exactly one bit set whenever valid_out=1. data_out=0 whenever valid_out=0.
- Out-of-range (encoded_in >= OUT_W):
  - The beat is accepted (consumes the handshake) but is never stored or forwarded.
  - err_out pulses 1 at edge N+1; occupancy is unchanged.
  - A simultaneous legal transfer on the output side proceeds normally.
- OUT_W == 2**IDX_W: err_out is tied 0.

Optional Feature:
- Macro: ONEHOT_DECODER_COUNT_EN.
- Defined:
  - Adds output port beat_cnt [15:0]: number of output transfers since reset.
  - Wraps 16'hFFFF -> 0; reset value 0.
  - Increments on the edge of a transfer; out-of-range beats are not counted.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Package onehot_decoder_pkg holds:
  - IDX_W_DEF=3 and OUT_W_DEF=8.
  - The occupancy enum typedef (EMPTY, ONE, TWO).
  - The beat_cnt width constant CNT_W=16.
- One sub-module is natural: onehot_dec, a purely combinational index -> one-hot plus in-range flag, parameterised by IDX_W/OUT_W. It is instantiated on the skid-to-output path; buffering and handshake stay in the top.

Test Plan:
- Sweep with ready_in=1: encoded_in=0..7 on consecutive cycles -> data_out=8'h01,02,04,...,80 each one cycle after accept. valid_out continuous, ready_out stays 1, err_out=0.
- Back-pressure: send 3,5,6 while ready_in=0 -> ready_out falls to 0 after 2 accepts. Beat 6 is held off. data_out holds 8'h08. Releasing ready_in yields 8'h08, 8'h20, 8'h40 in order.
- Out-of-range with OUT_W=6: send 2,7,4 -> err_out pulses once (cycle after 7 accepted). Output shows only 8'h04 then 8'h10 (6-bit: 6'h04, 6'h10).
- Simultaneous accept+transfer in ONE state, randomized ready_in over 200 beats -> scoreboard match, no drops or duplicates, data_out always one-hot when valid.
- Reset mid-stream: assert rst_n=0 for 1 edge while in TWO -> valid_out=0, data_out=0 next edge. ready_out=1 first cycle after release. The following beat 1 decodes to 8'h02.
- With ONEHOT_DECODER_COUNT_EN: 70000 transfers -> beat_cnt = 70000 mod 65536 = 4464. Out-of-range beats do not increment it.
